sprite_frame_ram: RTL and testbench
===================================

Name: sprite_frame_ram

Overview:
- Multi-frame sprite bitmap RAM for the VGA game sprites (ghosts, player).
- Stores NUM_FRAMES animation frames of a 2**SPR_W_BITS x 2**SPR_H_BITS sprite, indexed by pixel coordinates.
- Adds a self-advancing animation frame counter, horizontal mirroring, transparency flagging and a registered 2-stage read pipeline.
- Sits between the sprite position/compare logic and the pixel colour mux; one write port for runtime bitmap updates.

Parameters:
- SPR_W_BITS, 4, log2 sprite width in pixels (16).
- SPR_H_BITS, 4, log2 sprite height in pixels (16).
- FRAME_BITS, 2, frame-index width.
- NUM_FRAMES, 4, frames in use; range 1 to 2**FRAME_BITS.
- DATA_WIDTH, 2, colour-code bits per pixel.
- ANIM_TICKS, 8, frame_tick pulses per animation step; minimum 1.
- TRANSP_KEY, 0, colour code treated as transparent.
- FLASH_COLOR, 3, substitute colour in flash mode (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- wr_frame  in  FRAME_BITS  write frame index.
- wr_x  in  SPR_W_BITS  write column.
- wr_y  in  SPR_H_BITS  write row.
- din  in  DATA_WIDTH  write pixel.
- rd_en  in  1  read request this cycle.
- x  in  SPR_W_BITS  read column, sprite-relative.
- y  in  SPR_H_BITS  read row, sprite-relative.
- mirror_x  in  1  read column becomes (2**SPR_W_BITS-1)-x.
- frame_tick  in  1  one-cycle pulse, normally start of vsync.
- anim_en  in  1  animation counter enable.
- anim_clr  in  1  synchronous clear of the animation state.
- dout  out  DATA_WIDTH  pixel colour.
- dout_valid  out  1  dout corresponds to a request.
- transparent  out  1  dout equals TRANSP_KEY and is valid.
- cur_frame  out  FRAME_BITS  current animation frame.

Behaviour:
- Memory and addressing
  - Depth is 2**(FRAME_BITS+SPR_H_BITS+SPR_W_BITS).
  - Address is {frame, y, x}.
  - Memory contents are not reset.
- Writes
  - Written on the clk edge when we=1, at {wr_frame, wr_y, wr_x}.
  - Writes are independent of the read pipeline.
  - wr_frame >= NUM_FRAMES is still written but is never read by animation.
- Read pipeline, latency 2
  - Stage 1 on an edge with rd_en=1: latches address {cur_frame, y, mirror_x ? ~x : x} and sets v1. v1 is cleared when rd_en=0.
  - Stage 2: the RAM output register captures mem[addr1], and dout_valid<=v1.
  - dout and transparent are valid two edges after the rd_en cycle.
  - Full throughput: one request per cycle.
  - When dout_valid=0, dout holds its last value and transparent=0.
- Read-during-write at the same address: read-first. The old data is returned and the new data is visible on the next read.
- Animation counter
  - tick_cnt is an internal $clog2(ANIM_TICKS)+1-bit counter.
  - On an edge with anim_clr=1: tick_cnt<=0 and cur_frame<=0. anim_clr has priority over everything else.
  - Else, if anim_en=1 and frame_tick=1:
    - If tick_cnt==ANIM_TICKS-1, tick_cnt<=0 and cur_frame advances. cur_frame goes NUM_FRAMES-1 -> 0, else +1.
    - Otherwise tick_cnt<=tick_cnt+1.
  - With anim_en=0, tick_cnt and cur_frame hold.
  - With NUM_FRAMES=1, cur_frame stays 0.
- Frame-change coherence: the frame used by a read is cur_frame as sampled in stage 1. A frame advance in the same cycle affects only the next request, so frame switching within a pixel is glitch-free.
- Reset (reset_n=0, asynchronous)
  - dout=0, dout_valid=0, transparent=0, cur_frame=0.
  - tick_cnt=0 and v1=0.
  - Reset mid-read discards in-flight requests. The first valid output comes 2 edges after the first rd_en following release.

Optional Feature:
- Macro: SPRITE_FLASH_EN.
- When defined:
  - Adds input port flash (1 bit).
  - Stage 1 also latches f1 = flash & cur_frame[0].
  - In stage 2, if f1=1 and the RAM word != TRANSP_KEY, dout<=FLASH_COLOR. This gives a frightened-ghost blink.
  - transparent is always computed from the raw RAM word.
- When undefined: no flash port and no f1 register; dout is always the raw RAM word.

Test Plan:
1. Reset and first read
   - Stimulus: assert reset_n=0 mid-stream with rd_en=1, then release; pulse rd_en at x=0, y=0.
   - Response: dout_valid=0 until 2 edges after the first rd_en; cur_frame=0; dout=0.
2. Write then read, with mirroring
   - Stimulus: write frame 1, x=3, y=5, din=2; set cur_frame=1; read x=3, y=5, mirror_x=0.
   - Response: dout=2 two cycles later.
   - Stimulus: read x=12, mirror_x=1.
   - Response: dout=2 (~12=3).
3. Read-during-write
   - Stimulus: addr holds 1; same edge we=1, din=3 and rd_en=1 at that address.
   - Response: dout=1; the following read gives 3.
4. Animation wrap
   - Stimulus: ANIM_TICKS=2, NUM_FRAMES=3, anim_en=1; pulse frame_tick 6 times.
   - Response: cur_frame sequence 0,0,1,1,2,2 -> 0.
   - Stimulus: anim_clr with frame_tick in the same cycle.
   - Response: cur_frame=0 and tick_cnt=0.
5. Transparency and streaming
   - Stimulus: row of pixels 0,1,0,3 read on consecutive cycles.
   - Response: dout 0,1,0,3 with transparent 1,0,1,0 and dout_valid high for 4 consecutive cycles.
6. Flash mode (SPRITE_FLASH_EN)
   - Stimulus: flash=1, cur_frame=1, pixel=1.
   - Response: dout=3, transparent=0.
   - Stimulus: same with pixel=0.
   - Response: dout=0, transparent=1.
   - Stimulus: cur_frame=2.
   - Response: dout=raw pixel.

Source files
------------

// File: rtl/sprite_frame_ram.sv
// Multi-frame sprite bitmap RAM with self-advancing animation frame, mirroring, transparency flag and 2-stage read.
// Optional flash recolouring (frightened-ghost blink) is enabled by defining SPRITE_FLASH_EN.
module sprite_frame_ram #(
  parameter int SPR_W_BITS  = 4,
  parameter int SPR_H_BITS  = 4,
  parameter int FRAME_BITS  = 2,
  parameter int NUM_FRAMES  = 4,
  parameter int DATA_WIDTH  = 2,
  parameter int ANIM_TICKS  = 8,
  parameter int TRANSP_KEY  = 0,
  parameter int FLASH_COLOR = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [FRAME_BITS-1:0] wr_frame,
  input  logic [SPR_W_BITS-1:0] wr_x,
  input  logic [SPR_H_BITS-1:0] wr_y,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic [SPR_W_BITS-1:0] x,
  input  logic [SPR_H_BITS-1:0] y,
  input  logic                  mirror_x,
  input  logic                  frame_tick,
  input  logic                  anim_en,
  input  logic                  anim_clr,
`ifdef SPRITE_FLASH_EN
  input  logic                  flash,
`endif
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  transparent,
  output logic [FRAME_BITS-1:0] cur_frame
);

  localparam int ADDR_W = FRAME_BITS + SPR_H_BITS + SPR_W_BITS;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TICK_W = $clog2(ANIM_TICKS) + 1;

  localparam logic [DATA_WIDTH-1:0] KEY       = DATA_WIDTH'(TRANSP_KEY);
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(ANIM_TICKS - 1);
  localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(NUM_FRAMES - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;
  logic [SPR_W_BITS-1:0] rd_col;

  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q;
  logic                  transp_q;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [FRAME_BITS-1:0] cur_frame_q, cur_frame_d;

  assign wr_addr = {wr_frame, wr_y, wr_x};
  assign rd_col  = mirror_x ? ~x : x;
  assign rd_addr = {cur_frame_q, y, rd_col};

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= din;
    end
  end

  // Array is read on the request edge, so a write on that same edge returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata1_q <= mem_q[rd_addr];
    end
  end

`ifdef SPRITE_FLASH_EN
  logic f1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f1_q <= 1'b0;
    end else if (rd_en) begin
      f1_q <= flash & cur_frame_q[0];
    end
  end

  always_comb begin
    dout_d = rdata1_q;
    if (f1_q && (rdata1_q != KEY)) begin
      dout_d = DATA_WIDTH'(FLASH_COLOR);
    end
  end
`else
  always_comb begin
    dout_d = rdata1_q;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q         <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      transp_q     <= 1'b0;
    end else begin
      v1_q         <= rd_en;
      dout_valid_q <= v1_q;
      transp_q     <= v1_q && (rdata1_q == KEY);
      if (v1_q) begin
        dout_q <= dout_d;
      end
    end
  end

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    cur_frame_d = cur_frame_q;
    if (anim_clr) begin
      tick_cnt_d  = '0;
      cur_frame_d = '0;
    end else if (anim_en && frame_tick) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d  = '0;
        cur_frame_d = (cur_frame_q == FRAME_LAST) ? '0 : cur_frame_q + 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      cur_frame_q <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      cur_frame_q <= cur_frame_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign transparent = transp_q;
  assign cur_frame   = cur_frame_q;

endmodule

// File: tb/tb_sprite_frame_ram.sv
// Randomized and directed bench for sprite_frame_ram against a cycle-stamped reference model.
// Define SPRITE_FLASH_EN for both files to cover the flash recolouring.
module tb_sprite_frame_ram;

  localparam int W = 4, H = 4, FB = 2, NF = 3, DW = 2, AT = 2, KEY = 0, FC = 3;
  localparam int DEPTH = 1 << (FB + H + W);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          we = 1'b0;
  logic [FB-1:0] wr_frame = '0;
  logic [W-1:0]  wr_x = '0;
  logic [H-1:0]  wr_y = '0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  x = '0;
  logic [H-1:0]  y = '0;
  logic          mirror_x = 1'b0;
  logic          frame_tick = 1'b0;
  logic          anim_en = 1'b0;
  logic          anim_clr = 1'b0;
`ifdef SPRITE_FLASH_EN
  logic          flash = 1'b0;
`endif
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          transparent;
  logic [FB-1:0] cur_frame;

  always #5 clk = ~clk;

  sprite_frame_ram #(
    .SPR_W_BITS(W), .SPR_H_BITS(H), .FRAME_BITS(FB), .NUM_FRAMES(NF),
    .DATA_WIDTH(DW), .ANIM_TICKS(AT), .TRANSP_KEY(KEY), .FLASH_COLOR(FC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wr_frame(wr_frame), .wr_x(wr_x),
    .wr_y(wr_y), .din(din), .rd_en(rd_en), .x(x), .y(y), .mirror_x(mirror_x),
    .frame_tick(frame_tick), .anim_en(anim_en), .anim_clr(anim_clr),
`ifdef SPRITE_FLASH_EN
    .flash(flash),
`endif
    .dout(dout), .dout_valid(dout_valid), .transparent(transparent), .cur_frame(cur_frame)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: memory image, tick count since last clear, and a queue of
  // responses stamped with the edge on which they must appear.
  typedef struct { int due; int dat; int raw; } resp_t;
  int    mem_m [DEPTH];
  int    ticks_m = 0;
  int    edge_m = 0;
  int    last_dat_m = 0;
  resp_t resp_q [$];

  function automatic int frame_m();
    return (ticks_m / AT) % NF;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q.delete();
      ticks_m    = 0;
      edge_m     = 0;
      last_dat_m = 0;
    end else begin
      edge_m++;
      if (rd_en) begin
        int col, raw, dat;
        col = mirror_x ? (2**W - 1) - int'(x) : int'(x);
        raw = mem_m[(frame_m() << (H + W)) + (int'(y) << W) + col];
        dat = raw;
`ifdef SPRITE_FLASH_EN
        if (flash && (frame_m() % 2 == 1) && raw != KEY) dat = FC;
`endif
        resp_q.push_back('{due: edge_m + 1, dat: dat, raw: raw});
      end
      if (we) mem_m[(int'(wr_frame) << (H + W)) + (int'(wr_y) << W) + int'(wr_x)] = int'(din);
      if (anim_clr) ticks_m = 0;
      else if (anim_en && frame_tick) ticks_m++;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      bit exp_vld;
      int exp_raw;
      exp_vld = 1'b0;
      exp_raw = -1;
      if (resp_q.size() > 0 && resp_q[0].due == edge_m) begin
        resp_t r;
        r = resp_q.pop_front();
        exp_vld    = 1'b1;
        exp_raw    = r.raw;
        last_dat_m = r.dat;
      end
      chk_val("mon_valid", 32'(dout_valid), 32'(exp_vld));
      chk_val("mon_dout", 32'(dout), 32'(last_dat_m));
      chk_val("mon_transparent", 32'(transparent), 32'(exp_vld && exp_raw == KEY));
      chk_val("mon_cur_frame", 32'(cur_frame), 32'(frame_m()));
    end
  end

  task automatic wr(input logic [FB-1:0] f, input logic [W-1:0] xx, input logic [H-1:0] yy,
                    input logic [DW-1:0] d);
    we = 1'b1; wr_frame = f; wr_x = xx; wr_y = yy; din = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [W-1:0] xx, input logic [H-1:0] yy, input logic m);
    rd_en = 1'b1; x = xx; y = yy; mirror_x = m;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic goto_frame(input int n);
    anim_clr = 1'b1;
    @(negedge clk);
    anim_clr = 1'b0; anim_en = 1'b1; frame_tick = 1'b1;
    repeat (n * AT) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    #12 reset_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) begin
      logic [9:0] av;
      av = 10'(a);
      wr(av[9:8], av[3:0], av[7:4], DW'($urandom));
    end

    // Reset in the middle of a read stream, then a single read.
    rd_en = 1'b1;
    repeat (5) begin
      x = W'($urandom); y = H'($urandom);
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    chk_val("rst_dout", 32'(dout), 0);
    chk_val("rst_valid", 32'(dout_valid), 0);
    chk_val("rst_transparent", 32'(transparent), 0);
    chk_val("rst_cur_frame", 32'(cur_frame), 0);
    @(negedge clk);
    rd_en = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(4'd0, 4'd0, 1'b0);
    chk_val("first_rd_not_yet", 32'(dout_valid), 0);
    @(negedge clk);
    chk_val("first_rd_valid", 32'(dout_valid), 1);

    // Write then read, plain and mirrored.
    wr(2'd1, 4'd3, 4'd5, 2'd2);
    goto_frame(1);
    chk_val("frame_is_1", 32'(cur_frame), 1);
    rd(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    chk_val("rd_plain", 32'(dout), 2);
    rd(4'd12, 4'd5, 1'b1);
    @(negedge clk);
    chk_val("rd_mirror", 32'(dout), 2);

    // Read-during-write at the same address returns the old word.
    wr(2'd1, 4'd3, 4'd5, 2'd1);
    we = 1'b1; wr_frame = 2'd1; wr_x = 4'd3; wr_y = 4'd5; din = 2'd3;
    rd_en = 1'b1; x = 4'd3; y = 4'd5; mirror_x = 1'b0;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    chk_val("rdw_old", 32'(dout), 1);
    @(negedge clk);
    chk_val("rdw_new", 32'(dout), 3);

    // Animation wrap with ANIM_TICKS=2, NUM_FRAMES=3.
    anim_clr = 1'b1;
    @(negedge clk);
    anim_clr = 1'b0; anim_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      chk_val($sformatf("anim_tick%0d", k), 32'(cur_frame), 32'((k / 2) % 3));
    end
    frame_tick = 1'b1;
    @(negedge clk);
    anim_clr = 1'b1;
    @(negedge clk);
    anim_clr = 1'b0;
    chk_val("clr_with_tick", 32'(cur_frame), 0);
    @(negedge clk);
    chk_val("clr_tickcnt_zero", 32'(cur_frame), 0);
    @(negedge clk);
    frame_tick = 1'b0;
    chk_val("after_clr_two_ticks", 32'(cur_frame), 1);

    // Streaming row with transparent pixels.
    wr(2'd1, 4'd0, 4'd7, 2'd0);
    wr(2'd1, 4'd1, 4'd7, 2'd1);
    wr(2'd1, 4'd2, 4'd7, 2'd0);
    wr(2'd1, 4'd3, 4'd7, 2'd3);
    for (int i = 0; i <= 4; i++) begin
      int pix [4] = '{0, 1, 0, 3};
      rd_en = (i < 4); x = W'(i); y = 4'd7; mirror_x = 1'b0;
      @(negedge clk);
      if (i >= 1) begin
        chk_val($sformatf("stream_dout%0d", i - 1), 32'(dout), 32'(pix[i - 1]));
        chk_val($sformatf("stream_transp%0d", i - 1), 32'(transparent), 32'(pix[i - 1] == 0));
        chk_val($sformatf("stream_valid%0d", i - 1), 32'(dout_valid), 1);
      end
    end
    rd_en = 1'b0;

`ifdef SPRITE_FLASH_EN
    goto_frame(1);
    wr(2'd1, 4'd5, 4'd9, 2'd1);
    wr(2'd1, 4'd6, 4'd9, 2'd0);
    flash = 1'b1;
    rd(4'd5, 4'd9, 1'b0);
    @(negedge clk);
    chk_val("flash_dout", 32'(dout), 3);
    chk_val("flash_transp", 32'(transparent), 0);
    rd(4'd6, 4'd9, 1'b0);
    @(negedge clk);
    chk_val("flash_key_dout", 32'(dout), 0);
    chk_val("flash_key_transp", 32'(transparent), 1);
    goto_frame(2);
    wr(2'd2, 4'd5, 4'd9, 2'd1);
    rd(4'd5, 4'd9, 1'b0);
    @(negedge clk);
    chk_val("flash_even_frame", 32'(dout), 1);
`endif

    // Random traffic; the monitor compares every cycle.
    for (int c = 0; c < 3000; c++) begin
      we = ($urandom % 3) == 0;
      wr_frame = FB'($urandom); wr_x = W'($urandom); wr_y = H'($urandom); din = DW'($urandom);
      rd_en = ($urandom % 4) != 0;
      x = W'($urandom); y = H'($urandom); mirror_x = 1'($urandom);
      frame_tick = ($urandom % 3) == 0;
      anim_en = ($urandom % 8) != 0;
      anim_clr = ($urandom % 64) == 0;
`ifdef SPRITE_FLASH_EN
      flash = 1'($urandom);
`endif
      @(negedge clk);
    end
    we = 1'b0; rd_en = 1'b0; frame_tick = 1'b0; anim_clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
